// File: rtl/bus_arbiter4_pkg.sv
// Shared types and helpers for the four-way round-robin bus arbiter.
// Holds FSM encoding, requester count and the rotating priority search.
package bus_arbiter4_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Scan from last+4 down to last+1 so the nearest requester after last wins.
  function automatic logic [1:0] rr_pick(
    input logic [NREQ-1:0] req,
    input logic [1:0]      last
  );
    logic [1:0] idx;
    rr_pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/bus_arbiter4_if.sv
// Requester/slave bundle of the arbiter.
// master is the arbiter's view, slave is the surrounding system's view.
interface bus_arbiter4_if #(
  parameter int WIDTH = 32
);
  import bus_arbiter4_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  slv_valid;
  logic [WIDTH-1:0]      slv_data;
  logic                  slv_done;
  logic [WIDTH-1:0]      slv_rdata;
  logic [NREQ-1:0]       gnt;
  logic [1:0]            sel;
  logic                  busy;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ*WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    input  req, req_data, slv_done, slv_rdata,
    output slv_valid, slv_data, gnt, sel,
    output busy, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output req, req_data, slv_done, slv_rdata,
    input  slv_valid, slv_data, gnt, sel,
    input  busy, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/decode2to4.sv
// 2-to-4 data demultiplexer: Data appears on output S, others are zero.
// Used to steer a single response word to one requester lane.
module decode2to4 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] Data,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3
);

  assign Y0 = (S == 2'd0) ? Data : '0;
  assign Y1 = (S == 2'd1) ? Data : '0;
  assign Y2 = (S == 2'd2) ? Data : '0;
  assign Y3 = (S == 2'd3) ? Data : '0;

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter sharing one single-outstanding slave among four
// requesters; grant held until slv_done or timeout, response demuxed back.
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  bus_arbiter4_if.master bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t            state;
  logic [1:0]        sel_q;
  logic [1:0]        last;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic              slv_valid_q;
  logic              rsp_err_q;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  rdata_q;
  logic [1:0]        pick;
  logic              timed_out;
  logic [WIDTH-1:0]  rsp_word;
  logic [WIDTH-1:0]  y0, y1, y2, y3;

  assign pick      = rr_pick(bus.req, last);
  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel_q       <= 2'd0;
      last        <= 2'd3;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      slv_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cnt         <= '0;
      rdata_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          rsp_valid_q <= '0;
          rsp_err_q   <= 1'b0;
          if (|bus.req) begin
            sel_q       <= pick;
            gnt_q       <= NREQ'(1) << pick;
            last        <= pick;
            cnt         <= '0;
            slv_valid_q <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (bus.slv_done) begin
            rdata_q     <= bus.slv_rdata;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= gnt_q;
            gnt_q       <= '0;
            slv_valid_q <= 1'b0;
            state       <= RESP;
          end else if (timed_out) begin
            rdata_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= gnt_q;
            gnt_q       <= '0;
            slv_valid_q <= 1'b0;
            state       <= RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          rsp_err_q   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stale capture must never leak outside the single RESP cycle.
  assign rsp_word = (state == RESP) ? rdata_q : '0;

  decode2to4 #(.WIDTH(WIDTH)) u_rsp_demux (
    .Data (rsp_word),
    .S    (sel_q),
    .Y0   (y0),
    .Y1   (y1),
    .Y2   (y2),
    .Y3   (y3)
  );

  assign bus.rsp_data  = {y3, y2, y1, y0};
  assign bus.slv_data  = slv_valid_q
                       ? bus.req_data[sel_q*WIDTH +: WIDTH]
                       : '0;
  assign bus.slv_valid = slv_valid_q;
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Randomised self-checking bench for bus_arbiter4.
// Reference model: rotating priority pointer plus per-transaction outcome.
module tb_bus_arbiter4;

  localparam int W  = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;

  bus_arbiter4_if #(.WIDTH(W)) bus();

  bus_arbiter4 #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_last;

  logic [3:0]   o_gnt, o_rv, o_rv2, o_gnt_r;
  logic [1:0]   o_sel;
  logic [31:0]  o_sdata;
  logic         o_busy, o_err, o_err2, o_sv_r, o_busy_r, o_busy2;
  logic [127:0] o_rd, o_rd2;
  int           o_n;

  function automatic int model_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [127:0] place(input int idx, input logic [31:0] d);
    logic [127:0] v;
    v = '0;
    v[idx*32 +: 32] = d;
    return v;
  endfunction

  task automatic rand_data();
    bus.req_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called one negedge before the grant edge; plays slave and requester.
  task automatic serve(input int done_at, input logic [31:0] rd,
                       input int drop_at, input bit keep);
    @(negedge clk);
    o_gnt = bus.gnt; o_sel = bus.sel; o_sdata = bus.slv_data;
    o_busy = bus.busy; o_n = 0;
    while (bus.slv_valid === 1'b1 && o_n < 100) begin
      o_n++;
      bus.slv_done  = (o_n == done_at);
      bus.slv_rdata = (o_n == done_at) ? rd : $urandom;
      if (o_n == drop_at) bus.req[o_sel] = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (o_n >= 100) begin
      errors++; $display("FAIL serve_bound: busy cycles %0d, limit 100", o_n);
    end
    bus.slv_done = 1'b0;
    o_rv = bus.rsp_valid; o_rd = bus.rsp_data; o_err = bus.rsp_err;
    o_gnt_r = bus.gnt; o_sv_r = bus.slv_valid; o_busy_r = bus.busy;
    if (!keep) bus.req[o_sel] = 1'b0;
    @(negedge clk);
    o_rv2 = bus.rsp_valid; o_rd2 = bus.rsp_data;
    o_err2 = bus.rsp_err; o_busy2 = bus.busy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_last = 3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = '0; bus.slv_done = 1'b0; bus.slv_rdata = '0;
    rand_data();
    repeat (2) @(negedge clk);
    checks++; if (bus.gnt !== 4'b0) begin errors++; $display("FAIL rst_gnt got %b want 0000", bus.gnt); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", bus.sel); end
    checks++; if (bus.slv_valid !== 1'b0) begin errors++; $display("FAIL rst_slv_valid got %b want 0", bus.slv_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0000", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 128'b0) begin errors++; $display("FAIL rst_rsp_data got %h want 0", bus.rsp_data); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", bus.rsp_err); end
    reset = 1'b0;
    model_last = 3;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_single();
    rand_data();
    bus.req_data[2*W +: W] = 32'h1111_2222;
    bus.req = 4'b0100;
    model_last = model_pick(4'b0100, model_last);
    serve(3, 32'hDEAD_BEEF, 0, 0);
    checks++; if (o_gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", o_gnt); end
    checks++; if (o_sel !== 2'd2) begin errors++; $display("FAIL single_sel got %0d want 2", o_sel); end
    checks++; if (o_sdata !== 32'h1111_2222) begin errors++; $display("FAIL single_slv_data got %h want 11112222", o_sdata); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", o_busy); end
    checks++; if (o_n !== 3) begin errors++; $display("FAIL single_cycles got %0d want 3", o_n); end
    checks++; if (o_rv !== 4'b0100) begin errors++; $display("FAIL single_rsp_valid got %b want 0100", o_rv); end
    checks++; if (o_rd !== place(2, 32'hDEAD_BEEF)) begin errors++; $display("FAIL single_rsp_data got %h want %h", o_rd, place(2, 32'hDEAD_BEEF)); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err got %b want 0", o_err); end
    checks++; if (o_gnt_r !== 4'b0 || o_sv_r !== 1'b0 || o_busy_r !== 1'b1) begin errors++; $display("FAIL single_resp_state gnt %b slv_valid %b busy %b want 0000 0 1", o_gnt_r, o_sv_r, o_busy_r); end
    checks++; if (o_rv2 !== 4'b0 || o_rd2 !== 128'b0 || o_err2 !== 1'b0 || o_busy2 !== 1'b0) begin errors++; $display("FAIL single_after rv %b rd %h err %b busy %b want all 0", o_rv2, o_rd2, o_err2, o_busy2); end
    checks++; if (bus.sel !== 2'd2) begin errors++; $display("FAIL single_sel_hold got %0d want 2", bus.sel); end
  endtask

  task automatic test_fairness();
    int pulses[4];
    int exp;
    logic [31:0] rd;
    pulses = '{0, 0, 0, 0};
    do_reset();
    rand_data();
    bus.req = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      exp = model_pick(4'b1111, model_last);
      model_last = exp;
      rd = $urandom;
      serve(1, rd, 0, 1);
      checks++; if (o_gnt !== 4'(1 << exp)) begin errors++; $display("FAIL fair_gnt[%0d] got %b want %b", t, o_gnt, 4'(1 << exp)); end
      checks++; if (o_sdata !== bus.req_data[exp*W +: W]) begin errors++; $display("FAIL fair_slv_data[%0d] got %h want %h", t, o_sdata, bus.req_data[exp*W +: W]); end
      checks++; if (o_rd !== place(exp, rd)) begin errors++; $display("FAIL fair_rsp_data[%0d] got %h want %h", t, o_rd, place(exp, rd)); end
      if (t < 4)
        for (int i = 0; i < 4; i++) if (o_rv[i] === 1'b1) pulses[i]++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (pulses[i] != 1) begin errors++; $display("FAIL fair_round req%0d pulses %0d want 1", i, pulses[i]); end
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    rand_data();
    bus.req = 4'b0010;
    model_last = model_pick(4'b0010, model_last);
    serve(0, 32'h0, 0, 0);
    checks++; if (o_n !== TO) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", o_n, TO); end
    checks++; if (o_rv !== 4'b0010) begin errors++; $display("FAIL timeout_rsp_valid got %b want 0010", o_rv); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL timeout_rsp_err got %b want 1", o_err); end
    checks++; if (o_rd !== 128'b0) begin errors++; $display("FAIL timeout_rsp_data got %h want 0", o_rd); end
    checks++; if (o_busy2 !== 1'b0 || o_err2 !== 1'b0) begin errors++; $display("FAIL timeout_idle busy %b err %b want 0 0", o_busy2, o_err2); end
  endtask

  task automatic test_tie();
    int idx;
    logic [31:0] rd;
    bus.req = '0;
    bus.slv_done = 1'b1;
    bus.slv_rdata = $urandom;
    @(negedge clk);
    bus.slv_done = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0 || bus.slv_valid !== 1'b0) begin errors++; $display("FAIL idle_done busy %b gnt %b slv_valid %b want 0", bus.busy, bus.gnt, bus.slv_valid); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL idle_done_rsp got %b want 0000", bus.rsp_valid); end
    idx = $urandom_range(0, 3);
    rand_data();
    bus.req = 4'(1 << idx);
    model_last = model_pick(bus.req, model_last);
    rd = $urandom;
    serve(TO, rd, 0, 0);
    checks++; if (o_n !== TO) begin errors++; $display("FAIL tie_cycles got %0d want %0d", o_n, TO); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL tie_rsp_err got %b want 0", o_err); end
    checks++; if (o_rd !== place(idx, rd)) begin errors++; $display("FAIL tie_rsp_data got %h want %h", o_rd, place(idx, rd)); end
  endtask

  task automatic test_drop();
    rand_data();
    bus.req = 4'b0010;
    model_last = model_pick(4'b0010, model_last);
    serve(5, 32'hA5A5_A5A5, 2, 0);
    checks++; if (o_n !== 5) begin errors++; $display("FAIL drop_cycles got %0d want 5", o_n); end
    checks++; if (o_rv !== 4'b0010) begin errors++; $display("FAIL drop_rsp_valid got %b want 0010", o_rv); end
    checks++; if (o_rd !== place(1, 32'hA5A5_A5A5)) begin errors++; $display("FAIL drop_rsp_data got %h want %h", o_rd, place(1, 32'hA5A5_A5A5)); end
  endtask

  task automatic test_random();
    logic [3:0]  r;
    logic [31:0] rd;
    int exp, d, en;
    logic        eerr;
    for (int t = 0; t < 25; t++) begin
      r = bus.req | 4'($urandom_range(0, 15));
      if (r == 4'b0) r = 4'b0001;
      bus.req = r;
      rand_data();
      exp = model_pick(r, model_last);
      model_last = exp;
      d = $urandom_range(1, 20);
      rd = $urandom;
      en = (d <= TO) ? d : TO;
      eerr = (d > TO);
      serve(d, rd, 0, 0);
      checks++; if (o_gnt !== 4'(1 << exp)) begin errors++; $display("FAIL rnd_gnt[%0d] req %b got %b want %b", t, r, o_gnt, 4'(1 << exp)); end
      checks++; if (o_sdata !== bus.req_data[exp*W +: W]) begin errors++; $display("FAIL rnd_slv_data[%0d] got %h want %h", t, o_sdata, bus.req_data[exp*W +: W]); end
      checks++; if (o_n !== en) begin errors++; $display("FAIL rnd_cycles[%0d] got %0d want %0d", t, o_n, en); end
      checks++; if (o_rv !== 4'(1 << exp) || o_err !== eerr) begin errors++; $display("FAIL rnd_rsp[%0d] valid %b err %b want %b %b", t, o_rv, o_err, 4'(1 << exp), eerr); end
      checks++; if (o_rd !== place(exp, eerr ? 32'h0 : rd)) begin errors++; $display("FAIL rnd_rsp_data[%0d] got %h want %h", t, o_rd, place(exp, eerr ? 32'h0 : rd)); end
      checks++; if (o_rv2 !== 4'b0 || o_rd2 !== 128'b0 || o_busy2 !== 1'b0) begin errors++; $display("FAIL rnd_after[%0d] rv %b rd %h busy %b want 0", t, o_rv2, o_rd2, o_busy2); end
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    rand_data();
    bus.req = 4'b1000;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL mid_gnt got %b want 1000", bus.gnt); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.gnt !== 4'b0 || bus.sel !== 2'd0 || bus.slv_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst gnt %b sel %0d slv_valid %b busy %b want 0", bus.gnt, bus.sel, bus.slv_valid, bus.busy); end
    checks++; if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== 128'b0 || bus.rsp_err !== 1'b0 || bus.slv_data !== 32'b0) begin errors++; $display("FAIL mid_rst_rsp rv %b rd %h err %b sd %h want 0", bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.slv_data); end
    @(negedge clk);
    reset = 1'b0;
    model_last = 3;
    bus.req = 4'b1001;
    model_last = model_pick(4'b1001, model_last);
    serve(2, 32'h1234_5678, 0, 0);
    checks++; if (o_gnt !== 4'(1 << model_last)) begin errors++; $display("FAIL mid_first_gnt got %b want %b", o_gnt, 4'(1 << model_last)); end
    checks++; if (o_rd !== place(model_last, 32'h1234_5678)) begin errors++; $display("FAIL mid_rsp_data got %h want %h", o_rd, place(model_last, 32'h1234_5678)); end
    model_last = model_pick(bus.req, model_last);
    serve(1, 32'h0BAD_F00D, 0, 0);
    checks++; if (o_gnt !== 4'(1 << model_last)) begin errors++; $display("FAIL mid_second_gnt got %b want %b", o_gnt, 4'(1 << model_last)); end
    bus.req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_tie();
    test_drop();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
